// File: rtl/fp32_div_sqrt_issuer.sv
// Issue-side sequencer for the iterative FP32 divide/sqrt unit: pending queue, req/finished handshake,
// result register with valid/ready, flush draining. Define FP_DIVSQRT_ISSUE_QUEUE_EN for a 2-deep queue.
module fp32_div_sqrt_issuer #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [31:0]      issue_lhs,
  input  logic [31:0]      issue_rhs,
  input  logic             issue_is_divide,
  input  logic [2:0]       issue_round_mode,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic             flush,
  output logic [31:0]      unit_lhs,
  output logic [31:0]      unit_rhs,
  output logic             unit_is_divide,
  output logic [2:0]       unit_round_mode,
  output logic             unit_req,
  input  logic [31:0]      unit_result,
  input  logic [4:0]       unit_fflags,
  input  logic             unit_finished,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [4:0]       res_fflags,
  output logic [TAG_W-1:0] res_tag,
  output logic [1:0]       dbg_state
);

`ifdef FP_DIVSQRT_ISSUE_QUEUE_EN
  localparam int Q = 2;
`else
  localparam int Q = 1;
`endif
  localparam int PW = (Q > 1) ? $clog2(Q) : 1;
  localparam int QA = 1 << PW;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_BUSY, S_DRAIN} state_e;

  state_e           state_q;
  logic [31:0]      q_lhs_q  [QA];
  logic [31:0]      q_rhs_q  [QA];
  logic             q_div_q  [QA];
  logic [2:0]       q_rm_q   [QA];
  logic [TAG_W-1:0] q_tag_q  [QA];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [TAG_W-1:0] inflight_tag_q;
  logic             res_valid_q;
  logic [31:0]      res_data_q;
  logic [4:0]       res_fflags_q;
  logic [TAG_W-1:0] res_tag_q;

  logic head_valid, full, res_free, push, capture;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(Q - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_valid = (count_q != 2'd0);
  assign full       = (count_q == 2'(Q));
  assign res_free   = !res_valid_q || res_ready;
`ifdef FP_DIVSQRT_ISSUE_QUEUE_EN
  assign issue_ready = !flush && !full && (state_q != S_INIT) && (state_q != S_DRAIN);
`else
  assign issue_ready = !flush && !full && (state_q == S_IDLE);
`endif
  assign push = issue_valid && issue_ready;
  // A finished result can only be taken when the output register frees up this cycle.
  assign capture = (state_q == S_BUSY) && !flush && unit_finished && res_free;

  always_comb begin
    unit_req = 1'b0;
    case (state_q)
      S_IDLE:  unit_req = head_valid && unit_finished && !flush;
      S_BUSY:  unit_req = capture && head_valid;
      default: unit_req = 1'b0;
    endcase
  end

  always_comb begin
    rd_ptr_d = unit_req ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q + {1'b0, push} - {1'b0, unit_req};
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_lhs_q[wr_ptr_q] <= issue_lhs;
      q_rhs_q[wr_ptr_q] <= issue_rhs;
      q_div_q[wr_ptr_q] <= issue_is_divide;
      q_rm_q[wr_ptr_q]  <= issue_round_mode;
      q_tag_q[wr_ptr_q] <= issue_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_INIT;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= 2'd0;
      inflight_tag_q <= '0;
      res_valid_q    <= 1'b0;
      res_data_q     <= '0;
      res_fflags_q   <= '0;
      res_tag_q      <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (unit_req) inflight_tag_q <= q_tag_q[rd_ptr_q];
      if (flush) begin
        res_valid_q <= 1'b0;
      end else if (capture) begin
        res_valid_q  <= 1'b1;
        res_data_q   <= unit_result;
        res_fflags_q <= unit_fflags;
        res_tag_q    <= inflight_tag_q;
      end else if (res_ready) begin
        res_valid_q <= 1'b0;
      end
      case (state_q)
        S_INIT:  if (unit_finished) state_q <= S_IDLE;
        S_IDLE:  if (unit_req) state_q <= S_BUSY;
        S_BUSY: begin
          // The unit cannot be aborted, so a flush must wait out the current operation.
          if (flush) state_q <= S_DRAIN;
          else if (capture && !unit_req) state_q <= S_IDLE;
        end
        S_DRAIN: if (unit_finished) state_q <= S_IDLE;
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign unit_lhs        = q_lhs_q[rd_ptr_q];
  assign unit_rhs        = q_rhs_q[rd_ptr_q];
  assign unit_is_divide  = q_div_q[rd_ptr_q];
  assign unit_round_mode = q_rm_q[rd_ptr_q];
  assign res_valid       = res_valid_q;
  assign res_data        = res_data_q;
  assign res_fflags      = res_fflags_q;
  assign res_tag         = res_tag_q;
  assign dbg_state       = state_q;

endmodule

// File: doc/fp32_div_sqrt_issuer.md
# fp32_div_sqrt_issuer

Initiator-side sequencer for the iterative FP32 divide/square-root unit. It accepts tagged operations from the FP issue stage, queues them, and drives the unit's `req`/`finished` handshake. It captures each result with its flags and tag into an output register, and presents it to writeback with valid/ready flow control. It also handles pipeline flush: the unit cannot be aborted, so in-flight work is drained and its result discarded.

## Interface
- `TAG_W`, 4: width of the operation tag (ROB/destination id) carried alongside each op.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `issue_valid`  in  1  operation offered.
- `issue_ready`  out  1  operation accepted when `issue_valid & issue_ready`.
- `issue_lhs`, `issue_rhs`  in  32  operands (`rhs` ignored for sqrt).
- `issue_is_divide`  in  1  1 = divide, 0 = sqrt.
- `issue_round_mode`  in  3  RISC-V rm encoding.
- `issue_tag`  in  TAG_W  tag returned with the result.
- `flush`  in  1  kill all queued and in-flight operations.
- `unit_lhs`, `unit_rhs`  out  32  queue head operands.
- `unit_is_divide`  out  1  queue head operation type.
- `unit_round_mode`  out  3  queue head rounding mode.
- `unit_req`  out  1  start pulse; the unit samples it only while `unit_finished`=1.
- `unit_result`  in  32  unit result, stable while `unit_finished`=1 and no new req.
- `unit_fflags`  in  5  unit flags, same stability rule.
- `unit_finished`  in  1  unit idle / result valid.
- `res_valid`  out  1  result register full.
- `res_ready`  in  1  writeback consumes the result.
- `res_data`  out  32  result.
- `res_fflags`  out  5  NV, DZ, OF, UF, NX.
- `res_tag`  out  TAG_W  tag.

## Operation
- Pending queue: circular FIFO, depth Q (see Configuration). Push on issue handshake, pop on `unit_req`. `unit_*` operand outputs always reflect the head entry.
- An in-flight register holds the tag of the op inside the unit.
- FSM states:
  - INIT, entered on reset. The unit runs spurious iterations after reset, so the FSM waits for `unit_finished`=1, then goes to IDLE.
  - IDLE: the unit is free. If the head is valid: `unit_req`=1, pop, latch the head tag to in-flight, go to BUSY.
  - BUSY: wait for `unit_finished`=1. It reads 0 in the cycle after a req, so any 1 means done. Capture `unit_result`, `unit_fflags` and the in-flight tag into the result register when the register is empty or `res_ready`=1 that cycle. In the same cycle, if the head is valid, assert `unit_req` and pop (stay BUSY); otherwise go to IDLE. If the result register is blocked, hold in BUSY with `unit_req`=0; the unit keeps its result stable.
  - DRAIN, entered on `flush` while BUSY. Wait for `unit_finished`=1, discard the result, then go to IDLE.
- `flush`: in the next cycle the queue is empty and `res_valid`=0. INIT stays INIT and IDLE stays IDLE. `issue_ready`=0 during the flush cycle, so a simultaneous `issue_valid` is not accepted.
- `issue_ready` = `!flush & !queue_full & state != INIT & state != DRAIN`.
- Reset values: `issue_ready` 0, `unit_req` 0, `res_valid` 0, `res_data`/`res_fflags`/`res_tag` 0, queue empty.
- Reset mid-operation: the issuer returns to INIT and waits for `unit_finished`. The unit is reset by the same `rst`.

## Timing
- Empty pipeline, accept at cycle a:
  - `unit_req` is asserted at a+1.
  - Divide: `unit_finished` at a+17, `res_valid` at a+18.
  - Sqrt: `unit_finished` at a+15, `res_valid` at a+16.
- Back-to-back: the next req fires in the capture cycle, so throughput is one divide per 16 cycles and one sqrt per 14 cycles.
- `res_*` outputs are registered and hold steady while `res_valid & !res_ready`.

## Configuration
- `FP_DIVSQRT_ISSUE_QUEUE_EN` defined: Q=2.
  - Ops may be accepted while the unit is BUSY.
  - Back-to-back req in the capture cycle is enabled.
- Undefined: Q=1.
  - `issue_ready` also requires state IDLE.
  - One op in flight at a time; each op pays the full a+18 / a+16 latency.

## Test plan
- Reset, unit idle after 13 cycles: `issue_ready`=0 through INIT and rises the cycle after `unit_finished`=1. No `unit_req` occurs before that.
- Divide 0x40400000 / 0x40000000, rm 0, tag 5, accepted at a: `res_valid` at a+18 with 0x3FC00000, fflags 0, tag 5.
- Sqrt 0x40800000, tag 2: `res_valid` at a+16 with 0x40000000, fflags 0. Sqrt 0xBF800000 returns 0x7FC00000 with fflags 0x10.
- With QUEUE_EN, two divides (1/3, tags 1 and 2) issued on consecutive cycles:
  - Results are 0x3EAAAAAB, fflags 0x01.
  - Tag 2's result arrives exactly 16 cycles after tag 1's.
- `res_ready` held low while a second op finishes: state stays BUSY with `unit_req`=0. The second result appears the cycle after the first is consumed, with correct data and tag.
- `flush` at a+5 of a divide: no `res_valid` and `issue_ready`=0 until DRAIN exits at a+17. A new op issued afterwards returns the correct result.
